// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared constants for the JESD204 TPL DAC channel: select codes, PN seeds, sample width.
package ad_ip_jesd204_tpl_dac_pkg;

    localparam int SAMPLE_WIDTH = 16;

    localparam logic [3:0] SEL_DDS  = 4'd0;
    localparam logic [3:0] SEL_PAT  = 4'd1;
    localparam logic [3:0] SEL_DMA  = 4'd2;
    localparam logic [3:0] SEL_ZERO = 4'd3;
    localparam logic [3:0] SEL_PN7  = 4'd6;
    localparam logic [3:0] SEL_PN15 = 4'd7;
    localparam logic [3:0] SEL_RAMP = 4'd11;

    localparam logic [6:0]  PN7_SEED  = 7'h7F;
    localparam logic [14:0] PN15_SEED = 15'h7FFF;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_pn.sv
// Parallel PN7/PN15 generator producing W bits per cycle; slot 0 carries the earliest bits, MSB first.
module ad_ip_jesd204_tpl_dac_pn
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         reseed,
    input  logic         poly15,
    output logic [W-1:0] data
);

    logic [14:0] state_q;
    logic [14:0] state_d;
    logic [14:0] seed;
    logic [14:0] lfsr;
    logic        fb;

    always_comb begin
        seed = poly15 ? PN15_SEED : {8'h00, PN7_SEED};
        lfsr = reseed ? seed : state_q;
        fb   = 1'b0;
        data = '0;
        for (int i = 0; i < W; i++) begin
            if (poly15) begin
                data[(i / SAMPLE_WIDTH) * SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - (i % SAMPLE_WIDTH)] = lfsr[14];
                fb   = lfsr[14] ^ lfsr[13];
                lfsr = {lfsr[13:0], fb};
            end else begin
                data[(i / SAMPLE_WIDTH) * SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - (i % SAMPLE_WIDTH)] = lfsr[6];
                fb   = lfsr[6] ^ lfsr[5];
                lfsr = {8'h00, lfsr[5:0], fb};
            end
        end
        // Reseed still lands while the generator is idle so the next selection starts clean.
        state_d = en ? lfsr : (reseed ? seed : state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PN15_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_channel.sv
// Per-channel DAC sample source selector with one-cycle registered output.
// Optional PN7/PN15 sources are built only when AD_TPL_DAC_PN_EN is defined.
module ad_ip_jesd204_tpl_dac_channel
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int CHANNEL_ID      = 0
) (
    input  logic                                 link_clk,
    input  logic                                 link_resetn,
    input  logic                                 dac_sync,
    input  logic [3:0]                           dac_data_sel,
    input  logic                                 dac_dds_format,
    input  logic [15:0]                          dac_pat_data_0,
    input  logic [15:0]                          dac_pat_data_1,
    input  logic [SAMPLE_WIDTH*DATA_PATH_WIDTH-1:0] dds_data,
    input  logic                                 dma_valid,
    input  logic [SAMPLE_WIDTH*DATA_PATH_WIDTH-1:0] dma_data,
    output logic                                 dma_ready,
    output logic [SAMPLE_WIDTH*DATA_PATH_WIDTH-1:0] dac_data,
    output logic                                 dac_dunf
);

    localparam int DW = SAMPLE_WIDTH * DATA_PATH_WIDTH;

    // CHANNEL_ID is reserved for per-channel seed offsets and has no effect yet.
    if (CHANNEL_ID < 0) begin : g_bad_channel_id
    end

    logic [3:0]    sel_last_q;
    logic [3:0]    sel_eff;
    logic          rst_done_q;
    logic          reseed;
    logic [15:0]   ramp_q;
    logic [15:0]   ramp_d;
    logic [15:0]   ramp_base;
    logic [DW-1:0] dac_data_q;
    logic [DW-1:0] dac_data_d;
    logic          dac_dunf_q;
    logic          dac_dunf_d;

    always_comb begin
        case (dac_data_sel)
            SEL_DDS, SEL_PAT, SEL_DMA, SEL_RAMP: sel_eff = dac_data_sel;
`ifdef AD_TPL_DAC_PN_EN
            SEL_PN7, SEL_PN15:                   sel_eff = dac_data_sel;
`endif
            default:                             sel_eff = SEL_ZERO;
        endcase
    end

    assign reseed    = dac_sync | (dac_data_sel != sel_last_q);
    assign dma_ready = rst_done_q & (dac_data_sel == SEL_DMA);

`ifdef AD_TPL_DAC_PN_EN
    logic [DW-1:0] pn_data;

    ad_ip_jesd204_tpl_dac_pn #(
        .W (DW)
    ) i_pn (
        .clk    (link_clk),
        .rst_n  (link_resetn),
        .en     ((sel_eff == SEL_PN7) || (sel_eff == SEL_PN15)),
        .reseed (reseed),
        .poly15 (sel_eff == SEL_PN15),
        .data   (pn_data)
    );
`endif

    always_comb begin
        ramp_base  = reseed ? 16'h0000 : ramp_q;
        ramp_d     = ramp_base;
        dac_data_d = '0;
        dac_dunf_d = 1'b0;
        case (sel_eff)
            SEL_DDS: dac_data_d = dds_data;
            SEL_PAT: begin
                for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
                    dac_data_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = (k % 2 == 0) ? dac_pat_data_0 : dac_pat_data_1;
                end
            end
            SEL_DMA: begin
                if (dma_valid && dma_ready) begin
                    dac_data_d = dma_data;
                end else begin
                    dac_dunf_d = 1'b1;
                end
            end
`ifdef AD_TPL_DAC_PN_EN
            SEL_PN7, SEL_PN15: dac_data_d = pn_data;
`endif
            SEL_RAMP: begin
                for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
                    dac_data_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = ramp_base + 16'(k);
                end
                ramp_d = ramp_base + 16'(DATA_PATH_WIDTH);
            end
            default: dac_data_d = '0;
        endcase
        // Zero and a starved DMA cycle stay all-zero regardless of format.
        if (dac_dds_format && (sel_eff != SEL_ZERO) && !dac_dunf_d) begin
            for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
                dac_data_d[k*SAMPLE_WIDTH + SAMPLE_WIDTH - 1] = ~dac_data_d[k*SAMPLE_WIDTH + SAMPLE_WIDTH - 1];
            end
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            sel_last_q <= SEL_ZERO;
            rst_done_q <= 1'b0;
            ramp_q     <= 16'h0000;
            dac_data_q <= '0;
            dac_dunf_q <= 1'b0;
        end else begin
            sel_last_q <= dac_data_sel;
            rst_done_q <= 1'b1;
            ramp_q     <= ramp_d;
            dac_data_q <= dac_data_d;
            dac_dunf_q <= dac_dunf_d;
        end
    end

    assign dac_data = dac_data_q;
    assign dac_dunf = dac_dunf_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel.sv
// Scoreboard bench for the TPL DAC channel against a bit-stream / arithmetic reference model.
module tb_ad_ip_jesd204_tpl_dac_channel;

    localparam int DPW     = 4;
    localparam int DW      = 16 * DPW;
    localparam int SEQ_LEN = 65536;

    logic          link_clk = 1'b0;
    logic          link_resetn = 1'b1;
    logic          dac_sync = 1'b0;
    logic [3:0]    dac_data_sel = 4'd3;
    logic          dac_dds_format = 1'b0;
    logic [15:0]   dac_pat_data_0 = '0;
    logic [15:0]   dac_pat_data_1 = '0;
    logic [DW-1:0] dds_data = '0;
    logic          dma_valid = 1'b0;
    logic [DW-1:0] dma_data = '0;
    logic          dma_ready;
    logic [DW-1:0] dac_data;
    logic          dac_dunf;

    ad_ip_jesd204_tpl_dac_channel #(
        .DATA_PATH_WIDTH (DPW),
        .CHANNEL_ID      (0)
    ) dut (
        .link_clk       (link_clk),
        .link_resetn    (link_resetn),
        .dac_sync       (dac_sync),
        .dac_data_sel   (dac_data_sel),
        .dac_dds_format (dac_dds_format),
        .dac_pat_data_0 (dac_pat_data_0),
        .dac_pat_data_1 (dac_pat_data_1),
        .dds_data       (dds_data),
        .dma_valid      (dma_valid),
        .dma_data       (dma_data),
        .dma_ready      (dma_ready),
        .dac_data       (dac_data),
        .dac_dunf       (dac_dunf)
    );

    always #5 link_clk = ~link_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          dunf;
        string         tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    bit pn7_seq[];
    bit pn15_seq[];
    int m_sel_d;
    int m_pos;
    int m_ramp;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic int eff_sel(input logic [3:0] s);
        case (s)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd11: return int'(s);
`ifdef AD_TPL_DAC_PN_EN
            4'd6, 4'd7: return int'(s);
`endif
            default: return 3;
        endcase
    endfunction

    // Monitor: the DUT presents one word per cycle; compare it against the oldest expectation.
    initial begin
        forever begin
            @(posedge link_clk);
            #1;
            if (link_resetn && sb.size() > 0) begin
                mon_e = sb.pop_front();
                check({mon_e.tag, " data"}, dac_data, mon_e.data);
                check({mon_e.tag, " dunf"}, DW'(dac_dunf), DW'(mon_e.dunf));
            end
        end
    end

    task automatic step(input logic [3:0] s, input logic sy, input logic f,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [DW-1:0] dd, input logic v, input logic [DW-1:0] dm,
                        input string tag);
        exp_t x;
        int   e;
        bit   rs;
        @(negedge link_clk);
        dac_data_sel   = s;
        dac_sync       = sy;
        dac_dds_format = f;
        dac_pat_data_0 = a;
        dac_pat_data_1 = b;
        dds_data       = dd;
        dma_valid      = v;
        dma_data       = dm;
        #1;
        check({tag, " ready"}, DW'(dma_ready), DW'(s == 4'd2));

        e  = eff_sel(s);
        rs = sy || (int'(s) != m_sel_d);
        if (rs) begin
            m_pos  = 0;
            m_ramp = 0;
        end
        x.data = '0;
        x.dunf = 1'b0;
        x.tag  = tag;
        case (e)
            0: x.data = dd;
            1: for (int k = 0; k < DPW; k++) x.data[k*16 +: 16] = (k % 2 == 1) ? b : a;
            2: if (v) x.data = dm; else x.dunf = 1'b1;
            6, 7: begin
                if (m_pos + DW > SEQ_LEN) begin
                    errors++;
                    $display("FAIL %s pn model range pos %0d limit %0d", tag, m_pos, SEQ_LEN);
                end else begin
                    for (int i = 0; i < DW; i++) begin
                        x.data[(i / 16) * 16 + 15 - (i % 16)] = (e == 7) ? pn15_seq[m_pos + i] : pn7_seq[m_pos + i];
                    end
                    m_pos += DW;
                end
            end
            11: begin
                for (int k = 0; k < DPW; k++) x.data[k*16 +: 16] = 16'((m_ramp + k) % 65536);
                m_ramp = (m_ramp + DPW) % 65536;
            end
            default: x.data = '0;
        endcase
        if (f && e != 3 && !x.dunf) begin
            for (int k = 0; k < DPW; k++) x.data[k*16 + 15] = ~x.data[k*16 + 15];
        end
        m_sel_d = int'(s);
        sb.push_back(x);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge link_clk);
        link_resetn = 1'b0;
        sb.delete();
        #1;
        check("reset_async ready", DW'(dma_ready), '0);
        check("reset_async data", dac_data, '0);
        check("reset_async dunf", DW'(dac_dunf), '0);
        dac_data_sel = 4'd3;
        dac_sync     = 1'b0;
        dma_valid    = 1'b0;
        repeat (cycles) @(negedge link_clk);
        check("reset_hold data", dac_data, '0);
        check("reset_hold ready", DW'(dma_ready), '0);
        link_resetn = 1'b1;
        m_sel_d = 3;
        m_pos   = 0;
        m_ramp  = 0;
        @(posedge link_clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rsel;
        logic [3:0] sel_pool [8];

        pn7_seq  = new[SEQ_LEN];
        pn15_seq = new[SEQ_LEN];
        for (int n = 0; n < SEQ_LEN; n++) begin
            pn7_seq[n]  = (n < 7)  ? 1'b1 : (pn7_seq[n-7] ^ pn7_seq[n-6]);
            pn15_seq[n] = (n < 15) ? 1'b1 : (pn15_seq[n-15] ^ pn15_seq[n-14]);
        end
        m_sel_d = 3;
        m_pos   = 0;
        m_ramp  = 0;

        #2;
        do_reset(3);
        repeat (3) step(4'd3, 0, 0, '0, '0, '0, 0, '0, "idle");

        repeat (3) step(4'd1, 0, 0, 16'hA5A5, 16'h5A5A, '0, 0, '0, "pat");

        step(4'd2, 0, 0, '0, '0, '0, 1, 64'h0004_0003_0002_0001, "dma_w0");
        step(4'd2, 0, 0, '0, '0, '0, 0, 64'h0004_0003_0002_0001, "dma_unf");
        step(4'd2, 0, 0, '0, '0, '0, 1, 64'h0008_0007_0006_0005, "dma_w1");

        repeat (3) step(4'd11, 0, 0, '0, '0, '0, 0, '0, "ramp");
        step(4'd11, 1, 0, '0, '0, '0, 0, '0, "ramp_sync");
        repeat (2) step(4'd11, 0, 0, '0, '0, '0, 0, '0, "ramp_after_sync");
        step(4'd3, 0, 0, '0, '0, '0, 0, '0, "ramp_leave");
        repeat (16390) step(4'd11, 0, 0, '0, '0, '0, 0, '0, "ramp_wrap");

        repeat (40) step(4'd7, 0, 0, '0, '0, '0, 0, '0, "pn15");
        repeat (10) step(4'd6, 0, 0, '0, '0, '0, 0, '0, "pn7");
        step(4'd6, 1, 0, '0, '0, '0, 0, '0, "pn7_sync");
        repeat (4) step(4'd6, 0, 0, '0, '0, '0, 0, '0, "pn7_resume");
        repeat (3) step(4'd7, 0, 1, '0, '0, '0, 0, '0, "pn15_fmt");

        repeat (2) step(4'd1, 0, 1, 16'h0000, 16'h0000, '0, 0, '0, "fmt_pat");
        repeat (2) step(4'd3, 0, 1, 16'h0000, 16'h0000, '0, 0, '0, "fmt_zero");
        step(4'd0, 0, 1, '0, '0, {$urandom, $urandom}, 0, '0, "fmt_dds");
        step(4'd2, 0, 1, '0, '0, '0, 0, '0, "fmt_unf");
        step(4'd9, 0, 1, 16'h1234, 16'h5678, '0, 0, '0, "fmt_undef_code");

        sel_pool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd11, 4'd5};
        rsel = 4'd0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                rsel = ($urandom_range(0, 7) == 7) ? 4'($urandom_range(0, 15)) : sel_pool[$urandom_range(0, 6)];
            end
            step(rsel, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), {$urandom, $urandom}, "random");
        end

        repeat (2) step(4'd2, 0, 0, '0, '0, '0, 1, {$urandom, $urandom}, "pre_reset_dma");
        do_reset(2);
        repeat (2) step(4'd3, 0, 0, '0, '0, '0, 0, '0, "post_reset_idle");
        repeat (3) step(4'd11, 0, 0, '0, '0, '0, 0, '0, "post_reset_ramp");
        repeat (3) step(4'd7, 0, 0, '0, '0, '0, 0, '0, "post_reset_pn15");

        repeat (3) @(posedge link_clk);
        #2;
        check("drain", DW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
